alu_issue_ctrl: RTL

//  Issue/execute controller placed directly upstream of the combinational Hack-style ALU.
//  - Accepts 16-bit Hack instructions over a valid/ready handshake.
//  - Holds the A and D registers and fetches the M operand over a req/ack memory port.
//  - Drives ALU operands and the six control bits, and captures the ALU result.
//  - Writes back to A, D and M, and evaluates the jump condition for the fetch unit.

---
 rtl/alu_issue_ctrl_pkg.sv | 29 ++
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/alu_issue_ctrl_jump_eval.sv | 20 ++
 rtl/alu_issue_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared types, field indices and widths for the ALU issue controller
package alu_issue_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 15;

    // Hack instruction field bit positions
    localparam int I_TYPE    = 15;
    localparam int I_A       = 12;
    localparam int I_COMP_HI = 11;
    localparam int I_COMP_LO = 6;
    localparam int I_DEST_HI = 5;
    localparam int I_DEST_LO = 3;
    localparam int I_JMP_HI  = 2;
    localparam int I_JMP_LO  = 0;

    // Individual destination bits
    localparam int I_DA = 5;
    localparam int I_DD = 4;
    localparam int I_DM = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_M = 2'd1,
        EXEC = 2'd2,
        WR_M = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction, ALU and memory bundle between controller and its neighbours
interface alu_issue_ctrl_if
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;

    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic              alu_zx;
    logic              alu_nx;
    logic              alu_zy;
    logic              alu_ny;
    logic              alu_f;
    logic              alu_no;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ng;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_req;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_req;
    logic              mem_wr_ack;
    logic [DATA_W-1:0] mem_wr_data;

    modport master (
        input  instr_valid, instr, alu_out, alu_ng, mem_rd_ack, mem_rd_data, mem_wr_ack,
        output instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
               mem_addr, mem_rd_req, mem_wr_req, mem_wr_data
    );

    modport slave (
        output instr_valid, instr, alu_out, alu_ng, mem_rd_ack, mem_rd_data, mem_wr_ack,
        input  instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
               mem_addr, mem_rd_req, mem_wr_req, mem_wr_data
    );

endinterface

// File: rtl/alu_issue_ctrl_jump_eval.sv
// rtl/alu_issue_ctrl_jump_eval.sv - combinational jump condition from ALU result and jump bits
module alu_jump_eval #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ng,
    input  logic [2:0]        jmp,
    output logic              take
);
    logic lt;
    logic eq;
    logic gt;

    // Zero is derived here rather than trusting the ALU's own zr flag
    assign lt   = alu_ng;
    assign eq   = (alu_out == '0);
    assign gt   = !lt && !eq;
    assign take = (jmp[2] && lt) || (jmp[1] && eq) || (jmp[0] && gt);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - Hack instruction issue/execute controller; optional ALU_ISSUE_PERF_EN counters
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_instr_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    state_t            state;
    state_t            state_nxt;
    logic [I_A:0]      ir;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] res_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              accept;
    logic              take;

    assign accept = (state == IDLE) && bus.instr_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; A-instructions never leave IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && bus.instr[I_TYPE]) begin
                    state_nxt = bus.instr[I_A] ? RD_M : EXEC;
                end
            end
            RD_M: begin
                if (bus.mem_rd_ack) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = ir[I_DM] ? WR_M : IDLE;
            end
            WR_M: begin
                if (bus.mem_wr_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Architectural registers and operand/result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            a_reg     <= '0;
            d_reg     <= '0;
            m_q       <= '0;
            res_q     <= '0;
            wr_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!bus.instr[I_TYPE]) begin
                            a_reg <= {{(DATA_W-ADDR_W){1'b0}}, bus.instr[ADDR_W-1:0]};
                        end else begin
                            ir        <= bus.instr[I_A:0];
                            // M address is frozen to the pre-instruction A
                            wr_addr_q <= a_reg[ADDR_W-1:0];
                        end
                    end
                end
                RD_M: begin
                    if (bus.mem_rd_ack) begin
                        m_q <= bus.mem_rd_data;
                    end
                end
                EXEC: begin
                    if (ir[I_DD]) d_reg <= bus.alu_out;
                    if (ir[I_DA]) a_reg <= bus.alu_out;
                    if (ir[I_DM]) res_q <= bus.alu_out;
                end
                default: ;
            endcase
        end
    end

    alu_jump_eval #(.DATA_W(DATA_W)) u_jump (
        .alu_out (bus.alu_out),
        .alu_ng  (bus.alu_ng),
        .jmp     (ir[I_JMP_HI:I_JMP_LO]),
        .take    (take)
    );

    assign bus.instr_ready = (state == IDLE);
    assign bus.mem_rd_req  = (state == RD_M);
    assign bus.mem_wr_req  = (state == WR_M);
    assign bus.mem_addr    = (state == RD_M) ? a_reg[ADDR_W-1:0] :
                             (state == WR_M) ? wr_addr_q : '0;
    assign bus.mem_wr_data = res_q;

    assign bus.alu_x  = d_reg;
    assign bus.alu_y  = ir[I_A] ? m_q : a_reg;
    assign bus.alu_zx = ir[11];
    assign bus.alu_nx = ir[10];
    assign bus.alu_zy = ir[9];
    assign bus.alu_ny = ir[8];
    assign bus.alu_f  = ir[7];
    assign bus.alu_no = ir[6];

    assign pc_load   = (state == EXEC) && take;
    assign pc_target = wr_addr_q;

`ifdef ALU_ISSUE_PERF_EN
    // Accepted-instruction and memory-wait cycle counters, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) begin
                perf_instr_cnt <= perf_instr_cnt + 32'd1;
            end
            if (((state == RD_M) && !bus.mem_rd_ack) || ((state == WR_M) && !bus.mem_wr_ack)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
